// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, defaults and cache geometry helpers for the fetcher
package fetch_pkg;

    typedef enum logic [1:0] {
        S_LOOKUP = 2'd0,
        S_WAIT   = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Index bits of a direct-mapped cache holding one word per line
    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    // Tag bits left over from a 30-bit word address once the index is removed
    function automatic int tag_bits(input int lines);
        return 30 - $clog2(lines);
    endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// rtl/inst_fetcher_if.sv - memory-controller and decoder handshake bundle of the fetcher
interface inst_fetcher_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        fetch_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        issue_ready;
    logic        pc_change_flag;
    logic [31:0] pc_change;
    logic        flush;
    logic [31:0] flush_pc;

    modport master (
        output mem_req, mem_addr, fetch_ready, inst, pc,
        input  mem_done, mem_data, issue_ready, pc_change_flag, pc_change, flush, flush_pc
    );

    modport slave (
        input  mem_req, mem_addr, fetch_ready, inst, pc,
        output mem_done, mem_data, issue_ready, pc_change_flag, pc_change, flush, flush_pc
    );
endinterface

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped one-word-per-line instruction cache
module icache_dm
    import fetch_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [29:0] lookup_word,
    output logic        hit,
    output logic [31:0] lookup_data,
    input  logic        fill_we,
    input  logic [29:0] fill_word,
    input  logic [31:0] fill_data
);

    localparam int IDX  = idx_bits(LINES);
    localparam int TAGW = tag_bits(LINES);

    logic [LINES-1:0] valid;
    logic [TAGW-1:0]  tags [LINES];
    logic [31:0]      data [LINES];

    logic [IDX-1:0]  lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic [IDX-1:0]  fl_idx;
    logic [TAGW-1:0] fl_tag;

    assign lk_idx = lookup_word[IDX-1:0];
    assign lk_tag = lookup_word[29:IDX];
    assign fl_idx = fill_word[IDX-1:0];
    assign fl_tag = fill_word[29:IDX];

    assign hit         = valid[lk_idx] && (tags[lk_idx] == lk_tag);
    assign lookup_data = data[lk_idx];

    // Valid bits are the only cache state that reset must clear
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid <= '0;
        end else if (fill_we) begin
            valid[fl_idx] <= 1'b1;
        end
    end

    // Tag and data are meaningless until the valid bit is set, so they carry no reset
    always_ff @(posedge clk_in) begin
        if (fill_we) begin
            tags[fl_idx] <= fl_tag;
            data[fl_idx] <= fill_data;
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - fetch FSM, PC register and memory handshake feeding the decoder
module inst_fetcher
    import fetch_pkg::*;
#(
    parameter int          ICACHE_LINES = 16,
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT
) (
    input logic            clk_in,
    input logic            rst_in,
    input logic            rdy_in,
    inst_fetcher_if.master bus
);

    state_t      state, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] inst_q, inst_n;
    logic [31:0] mem_addr_q, mem_addr_n;
    logic        fetch_ready_q, fetch_ready_n;
    logic        mem_req_q, mem_req_n;

    logic        hit;
    logic [31:0] hit_data;
    logic        fill_we;

    icache_dm #(.LINES(ICACHE_LINES)) u_icache (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .lookup_word (pc_q[31:2]),
        .hit         (hit),
        .lookup_data (hit_data),
        .fill_we     (fill_we),
        .fill_word   (mem_addr_q[31:2]),
        .fill_data   (bus.mem_data)
    );

    assign bus.pc          = pc_q;
    assign bus.inst        = inst_q;
    assign bus.fetch_ready = fetch_ready_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;

    // Architectural registers; everything the decoder and memory see is registered here
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= S_LOOKUP;
            pc_q          <= RESET_PC;
            inst_q        <= '0;
            fetch_ready_q <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
        end else begin
            state         <= state_n;
            pc_q          <= pc_n;
            inst_q        <= inst_n;
            fetch_ready_q <= fetch_ready_n;
            mem_req_q     <= mem_req_n;
            mem_addr_q    <= mem_addr_n;
        end
    end

    // Next state: pause freezes all, flush beats issue, issue beats lookup/refill
    always_comb begin
        state_n       = state;
        pc_n          = pc_q;
        inst_n        = inst_q;
        fetch_ready_n = fetch_ready_q;
        mem_req_n     = mem_req_q;
        mem_addr_n    = mem_addr_q;
        fill_we       = 1'b0;
        if (rdy_in) begin
            if (bus.flush) begin
                pc_n          = bus.flush_pc;
                fetch_ready_n = 1'b0;
                mem_req_n     = 1'b0;
                state_n       = S_LOOKUP;
                // A word landing in the flush cycle is still worth caching, just not issuing
                fill_we       = (state == S_WAIT) && bus.mem_done;
            end else begin
                case (state)
                    S_LOOKUP: begin
                        if (hit) begin
                            inst_n        = hit_data;
                            fetch_ready_n = 1'b1;
                            state_n       = S_HOLD;
                        end else begin
                            mem_req_n  = 1'b1;
                            mem_addr_n = {pc_q[31:2], 2'b00};
                            state_n    = S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (bus.mem_done) begin
                            fill_we       = 1'b1;
                            inst_n        = bus.mem_data;
                            fetch_ready_n = 1'b1;
                            mem_req_n     = 1'b0;
                            state_n       = S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (bus.issue_ready) begin
                            pc_n          = bus.pc_change_flag ? bus.pc_change : pc_q + 32'd4;
                            fetch_ready_n = 1'b0;
                            state_n       = S_LOOKUP;
                        end
                    end
                    default: begin
                        state_n = S_LOOKUP;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// tb/tb_inst_fetcher.sv - directed and randomized self-checking bench for inst_fetcher
module tb_inst_fetcher;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    inst_fetcher_if bus ();

    inst_fetcher #(.ICACHE_LINES(16), .RESET_PC(32'h0)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] D0   = 32'h0050_0093;
    localparam logic [31:0] D4   = 32'h0010_0113;
    localparam logic [31:0] D8   = 32'h0020_8193;
    localparam logic [31:0] D40  = 32'h4000_0413;
    localparam logic [31:0] D100 = 32'h1000_0513;

    // Reference cache: which aligned address each line holds and its word
    bit          m_valid [16];
    logic [31:0] m_addr  [16];
    logic [31:0] m_data  [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] t, i, lo;
        t  = $urandom_range(0, 3);
        i  = $urandom_range(0, 15);
        lo = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0;
        return t * 64 + i * 4 + lo;
    endfunction

    task automatic serve(input logic [31:0] data);
        bus.mem_done = 1'b1;
        bus.mem_data = data;
        tick();
        bus.mem_done = 1'b0;
        bus.mem_data = 32'hdead_beef;
    endtask

    task automatic issue(input logic flag, input logic [31:0] target);
        bus.issue_ready    = 1'b1;
        bus.pc_change_flag = flag;
        bus.pc_change      = target;
        tick();
        bus.issue_ready    = 1'b0;
        bus.pc_change_flag = 1'b0;
    endtask

    task automatic do_flush(input logic [31:0] target);
        bus.flush    = 1'b1;
        bus.flush_pc = target;
        tick();
        bus.flush    = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_pc, exp_inst, a, tgt;
        int idx;
        bit fd;

        rst_in = 1'b1;
        rdy_in = 1'b1;
        bus.mem_done = 0; bus.mem_data = 0; bus.issue_ready = 0; bus.pc_change_flag = 0;
        bus.pc_change = 0; bus.flush = 0; bus.flush_pc = 0;
        tick(); tick();
        check("rst_pc", bus.pc, 32'h0);
        check("rst_inst", bus.inst, 32'h0);
        check("rst_ready", bus.fetch_ready, 0);
        check("rst_req", bus.mem_req, 0);
        check("rst_addr", bus.mem_addr, 32'h0);

        // Cold start
        rst_in = 1'b0;
        tick();
        check("cold_req", bus.mem_req, 1);
        check("cold_addr", bus.mem_addr, 32'h0);
        check("cold_ready0", bus.fetch_ready, 0);
        serve(D0);
        check("cold_ready", bus.fetch_ready, 1);
        check("cold_inst", bus.inst, D0);
        check("cold_pc", bus.pc, 32'h0);
        check("cold_req_fall", bus.mem_req, 0);
        issue(0, 0);
        check("iss_ready0", bus.fetch_ready, 0);
        check("iss_pc4", bus.pc, 32'h4);
        tick();
        check("miss4_req", bus.mem_req, 1);
        check("miss4_addr", bus.mem_addr, 32'h4);
        serve(D4);
        check("miss4_inst", bus.inst, D4);
        issue(0, 0);
        tick();
        check("miss8_addr", bus.mem_addr, 32'h8);
        serve(D8);
        check("miss8_inst", bus.inst, D8);

        // Loop refetch from cache after flush
        do_flush(32'h0);
        check("fl_ready0", bus.fetch_ready, 0);
        check("fl_pc", bus.pc, 32'h0);
        tick();
        check("fl_hit_ready", bus.fetch_ready, 1);
        check("fl_hit_inst", bus.inst, D0);
        check("fl_hit_noreq", bus.mem_req, 0);
        issue(0, 0);
        tick();
        check("hit4_inst", bus.inst, D4);
        issue(0, 0);
        // JAL-looking pulse while nothing is held must be ignored
        bus.issue_ready = 1; bus.pc_change_flag = 1; bus.pc_change = 32'h80;
        tick();
        bus.issue_ready = 0; bus.pc_change_flag = 0;
        check("ign_pc", bus.pc, 32'h8);
        check("ign_ready", bus.fetch_ready, 1);
        check("ign_inst", bus.inst, D8);

        // JAL to 0x40, conflicting with line 0
        issue(1, 32'h40);
        check("jal_pc", bus.pc, 32'h40);
        tick();
        check("conf_req", bus.mem_req, 1);
        check("conf_addr", bus.mem_addr, 32'h40);
        serve(D40);
        check("conf_inst", bus.inst, D40);
        do_flush(32'h0);
        tick();
        check("evict_req", bus.mem_req, 1);
        check("evict_addr", bus.mem_addr, 32'h0);
        serve(D0);
        check("evict_inst", bus.inst, D0);

        // Flush colliding with mem_done while waiting on 0x100
        issue(1, 32'h100);
        tick();
        check("w100_addr", bus.mem_addr, 32'h100);
        bus.mem_done = 1; bus.mem_data = D100;
        do_flush(32'h4);
        bus.mem_done = 0;
        check("fw_ready", bus.fetch_ready, 0);
        check("fw_req", bus.mem_req, 0);
        check("fw_pc", bus.pc, 32'h4);
        check("fw_inst", bus.inst, D0);
        tick();
        check("fw_hit4", bus.inst, D4);
        issue(1, 32'h100);
        tick();
        check("h100_ready", bus.fetch_ready, 1);
        check("h100_inst", bus.inst, D100);
        check("h100_noreq", bus.mem_req, 0);

        // Pause in S_HOLD with issue_ready asserted
        rdy_in = 0;
        bus.issue_ready = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("pause_pc", bus.pc, 32'h100);
            check("pause_inst", bus.inst, D100);
        end
        rdy_in = 1;
        tick();
        bus.issue_ready = 0;
        check("resume_pc", bus.pc, 32'h104);
        check("resume_ready", bus.fetch_ready, 0);

        // Reset while a miss is outstanding
        tick();
        check("mid_req", bus.mem_req, 1);
        rst_in = 1;
        #1;
        check("arst_pc", bus.pc, 32'h0);
        check("arst_req", bus.mem_req, 0);
        check("arst_addr", bus.mem_addr, 32'h0);
        check("arst_inst", bus.inst, 32'h0);
        check("arst_ready", bus.fetch_ready, 0);
        tick();
        rst_in = 0;

        // Randomized run against the reference cache
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
        exp_pc = 32'h0;
        exp_inst = 32'h0;
        for (int it = 0; it < 300; it++) begin
            check("r_pc", bus.pc, exp_pc);
            check("r_idle", bus.fetch_ready, 0);
            a = exp_pc & ~32'h3;
            idx = int'((a >> 2) % 16);
            tick();
            if (m_valid[idx] && m_addr[idx] == a) begin
                check("r_hit_ready", bus.fetch_ready, 1);
                check("r_hit_inst", bus.inst, m_data[idx]);
                check("r_hit_noreq", bus.mem_req, 0);
                exp_inst = m_data[idx];
            end else begin
                check("r_miss_req", bus.mem_req, 1);
                check("r_miss_addr", bus.mem_addr, a);
                check("r_miss_ready", bus.fetch_ready, 0);
                repeat ($urandom_range(0, 3)) begin
                    tick();
                    check("r_wait_req", bus.mem_req, 1);
                    check("r_wait_addr", bus.mem_addr, a);
                end
                if ($urandom_range(0, 5) == 0) begin
                    fd = 1'($urandom_range(0, 1));
                    tgt = pick_addr();
                    bus.mem_done = fd;
                    bus.mem_data = mem_word(a);
                    do_flush(tgt);
                    bus.mem_done = 0;
                    if (fd) begin
                        m_valid[idx] = 1; m_addr[idx] = a; m_data[idx] = mem_word(a);
                    end
                    check("r_fw_ready", bus.fetch_ready, 0);
                    check("r_fw_req", bus.mem_req, 0);
                    check("r_fw_inst", bus.inst, exp_inst);
                    exp_pc = tgt;
                    continue;
                end
                serve(mem_word(a));
                m_valid[idx] = 1; m_addr[idx] = a; m_data[idx] = mem_word(a);
                exp_inst = mem_word(a);
                check("r_fill_ready", bus.fetch_ready, 1);
                check("r_fill_inst", bus.inst, exp_inst);
                check("r_fill_req", bus.mem_req, 0);
            end
            repeat ($urandom_range(0, 2)) begin
                rdy_in = 1'($urandom_range(0, 1));
                bus.issue_ready = !rdy_in;
                bus.pc_change_flag = 1'($urandom_range(0, 1));
                bus.pc_change = pick_addr();
                tick();
                check("r_hold_pc", bus.pc, exp_pc);
                check("r_hold_inst", bus.inst, exp_inst);
            end
            rdy_in = 1;
            bus.issue_ready = 0;
            bus.pc_change_flag = 0;
            if ($urandom_range(0, 4) == 0) begin
                exp_pc = pick_addr();
                do_flush(exp_pc);
            end else if ($urandom_range(0, 2) == 0) begin
                exp_pc = pick_addr();
                issue(1, exp_pc);
            end else begin
                exp_pc = exp_pc + 32'd4;
                issue(0, 32'hffff_fff0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
